// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver that pairs with uart_tx.
// - rx is asynchronous to clk and passes through a 2-FF synchroniser.
// - Each bit is sampled near its centre.
// - Outputs are the received byte, a one-cycle valid strobe and a
//   one-cycle framing-error strobe.
// Optional build macro UART_RX_PARITY_EN switches the frame to 8E1 and
// drives the parity_err strobe. Without the macro, parity_err is tied to 0.
module uart_rx #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,        // asynchronous, active-low
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_e;

    logic       rx_meta_q, rx_s_q;
    state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       par_bad;

`ifdef UART_RX_PARITY_EN
    logic       par_q, par_d;
    logic       perr_q, perr_d;

    // Even parity: the parity bit must equal the XOR of the data bits.
    assign par_bad = par_q ^ (^shift_q);
`else
    assign par_bad = 1'b0;
`endif

    // Two-flop synchroniser on the asynchronous serial line.
    // Both flops reset to 1 so that reset looks like an idle line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments give every flop the value from
            // before the edge. A blocking chain here would collapse the two
            // synchroniser stages into one.
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receiver state, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // Next-state logic: find the start edge, confirm it at half a bit,
    // then take one sample per bit period at the bit centre.
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so
        // no path can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // A line that is high again at mid-start was a glitch.
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                    perr_d = par_bad;
`endif
                    if (rx_s_q) begin
                        // Back in IDLE at stop centre, so a start edge half
                        // a bit later is still caught.
                        state_d = S_IDLE;
                        if (!par_bad) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_BREAK: begin
                // A line held low reports one frame error and then waits here.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_START);
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized line-level stimulus for uart_rx.
// A frame-level model predicts, per clock cycle, when valid, frame_err,
// parity_err and busy must be high, and what data_out must hold.
module tb_uart_rx;

    localparam int C = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NB      = 11;   // start + 8 data + parity + stop
    localparam int LAT_LIT = 87;   // 2 sync + 1 detect + 4 half bit + 10*8
`else
    localparam int NB      = 10;   // start + 8 data + stop
    localparam int LAT_LIT = 79;   // 2 sync + 1 detect + 4 half bit + 9*8
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data_out;
    logic       valid, busy, frame_err, parity_err;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .valid      (valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected events, keyed by the cycle in which they must be visible.
    logic [7:0] exp_valid_at[int];
    bit         exp_ferr_at[int];
    bit         exp_perr_at[int];
    bit         exp_busy_at[int];
    logic [7:0] exp_data = 8'h00;

    int         n_valid_seen = 0;
    int         n_ferr_seen  = 0;
    int         last_valid_cyc = 0;
    logic [7:0] got_q[$];

    // Compare the DUT against the model on every cycle, away from the edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                exp_valid_at.delete();
                exp_ferr_at.delete();
                exp_perr_at.delete();
                exp_busy_at.delete();
                exp_data = 8'h00;
                check("rst_valid", valid, 0);
                check("rst_frame_err", frame_err, 0);
                check("rst_parity_err", parity_err, 0);
                check("rst_busy", busy, 0);
                check("rst_data_out", data_out, 0);
            end else begin
                if (exp_valid_at.exists(cyc)) exp_data = exp_valid_at[cyc];
                check("valid", valid, exp_valid_at.exists(cyc));
                check("frame_err", frame_err, exp_ferr_at.exists(cyc));
                check("parity_err", parity_err, exp_perr_at.exists(cyc));
                check("busy", busy, exp_busy_at.exists(cyc));
                check("data_out", data_out, exp_data);
                if (valid) begin
                    n_valid_seen++;
                    last_valid_cyc = cyc;
                    got_q.push_back(data_out);
                end
                if (frame_err) n_ferr_seen++;
            end
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame starting at this negedge and record what it must produce.
    // The line change at cycle k is acted on at k+3 (2 sync flops + detect).
    // The start is confirmed half a bit later, and the stop bit is sampled
    // (NB-1) bit periods after that.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
        int k;
        int s;
        k = cyc;
        s = k + 3 + C / 2 + C * (NB - 1);
        for (int c = k + 3 + C / 2; c < s; c++) exp_busy_at[c] = 1'b1;
        if (stop_ok) begin
            if (par_ok) exp_valid_at[s] = d;
            else        exp_perr_at[s]  = 1'b1;
        end else begin
            exp_ferr_at[s] = 1'b1;
            if (!par_ok) exp_perr_at[s] = 1'b1;
            // Busy stays high until the line is seen high again after the frame.
            for (int c = s; c <= k + C * NB + 2; c++) exp_busy_at[c] = 1'b1;
        end
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (C) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_ok ? (^d) : ~(^d);
        repeat (C) @(negedge clk);
`endif
        rx = stop_ok;
        repeat (C) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic glitch(input int len);
        rx = 1'b0;
        repeat (len) @(negedge clk);
        rx = 1'b1;
    endtask

    // Main stimulus sequence.
    initial begin
        int k0;
        int nv;
        logic [7:0] d;
        int r;

        rx  = 1'b1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        idle(10);

        // First byte after reset: fixed latency and value.
        k0 = cyc;
        send_frame(8'h03, 1'b1, 1'b1);
        idle(6);
        check("t1_latency", last_valid_cyc - k0, LAT_LIT);
        check("t1_data", data_out, 8'h03);
        check("t1_valid_count", n_valid_seen, 1);

        // Two frames with no idle gap between them.
        send_frame(8'hA5, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(6);
        check("t2_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("t2_first", got_q[1], 8'hA5);
            check("t2_second", got_q[2], 8'h3C);
        end

        // A short low glitch must be rejected.
        glitch(2);
        idle(20);
        check("t3_no_valid", n_valid_seen, 3);
        check("t3_no_ferr", n_ferr_seen, 0);

        // A bad stop bit gives one frame error, and the byte is kept.
        send_frame(8'h55, 1'b0, 1'b1);
        idle(20);
        check("t4_ferr_count", n_ferr_seen, 1);
        check("t4_no_valid", n_valid_seen, 3);
        check("t4_data_kept", data_out, 8'h3C);
        send_frame(8'h81, 1'b1, 1'b1);
        idle(6);
        check("t4_next_data", data_out, 8'h81);

        // Reset in the middle of data bit 4, released with the line idle.
        k0 = cyc;
        for (int c = k0 + 3 + C / 2; c < k0 + 400; c++) exp_busy_at[c] = 1'b1;
        d  = 8'h6B;
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (C) @(negedge clk);
        end
        rst = 1'b0;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        idle(4);
        check("t5_data_reset", data_out, 8'h00);
        nv = n_valid_seen;
        send_frame(8'h7E, 1'b1, 1'b1);
        idle(6);
        check("t5_data", data_out, 8'h7E);
        check("t5_one_valid", n_valid_seen, nv + 1);

`ifdef UART_RX_PARITY_EN
        // Wrong parity: no update. Correct parity: byte is accepted.
        send_frame(8'h07, 1'b1, 1'b0);
        idle(6);
        check("t6_bad_parity_keeps", data_out, 8'h7E);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(6);
        check("t6_good_parity", data_out, 8'h07);
`endif

        // Random mix of frames, gaps, glitches and bad stop bits.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            d = 8'($urandom_range(0, 255));
            if (r == 0) begin
                glitch($urandom_range(1, 3));
                idle(10);
            end else if (r == 1) begin
                send_frame(d, 1'b0, 1'b1);
                idle(8 + $urandom_range(0, 8));
`ifdef UART_RX_PARITY_EN
            end else if (r == 2) begin
                send_frame(d, 1'b1, 1'b0);
                idle($urandom_range(0, 12));
`endif
            end else begin
                send_frame(d, 1'b1, 1'b1);
                idle($urandom_range(0, 12));
            end
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
